// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART blocks.
// Holds the state encoding, legal parameter ranges and the bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;
  localparam int unsigned BIT_CNT_MIN   = 4;

  // Wide enough to count any legal data or stop bit index.
  localparam int unsigned IDX_W = 4;

  function automatic int unsigned calc_bit_cnt(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_CNT-1 while enabled, flags the mid-bit
// sample point and the last cycle of each bit.
module uart_bit_timer #(
  parameter int unsigned BIT_CNT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sample_c,
  output logic bit_end_c
);

  localparam int unsigned CNT_W = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  logic [CNT_W-1:0] cnt_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_bit <= '0;
    end else if (clr) begin
      cnt_bit <= '0;
    end else if (en) begin
      if (cnt_bit == CNT_W'(BIT_CNT - 1)) cnt_bit <= '0;
      else                                cnt_bit <= cnt_bit + CNT_W'(1);
    end
  end

  assign sample_c  = en && (cnt_bit == CNT_W'(BIT_CNT / 2 - 1));
  assign bit_end_c = en && (cnt_bit == CNT_W'(BIT_CNT - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// with false-start rejection and one-cycle valid / error strobes.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned BIT_CNT = calc_bit_cnt(CLK_FREQ, BAUD);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      BIT_CNT < BIT_CNT_MIN) begin : g_bad_cfg
    $error("uart_rx_param: illegal parameter combination");
  end

  logic ff0, ff1, ff2;
  logic fall_c, stop_low_c, sample_c, bit_end_c, timer_en_c, timer_clr_c;

  state_t               state, state_n;
  logic [IDX_W-1:0]     cnt_idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic                 par_q, par_n, stop_q, stop_n;
  logic                 vld_n, perr_n, ferr_n;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {ff0, ff1, ff2} <= 3'b111;
    else        {ff0, ff1, ff2} <= {rx_uart, ff0, ff1};
  end

  assign fall_c      = ~ff1 & ff2;
  assign stop_low_c  = stop_q | ~ff1;
  assign timer_en_c  = (state != ST_IDLE);
  assign timer_clr_c = (state_n == ST_IDLE);

  uart_bit_timer #(.BIT_CNT(BIT_CNT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (timer_en_c),
    .clr       (timer_clr_c),
    .sample_c  (sample_c),
    .bit_end_c (bit_end_c)
  );

  always_comb begin
    state_n = state;
    idx_n   = cnt_idx;
    shreg_n = shreg;
    par_n   = par_q;
    stop_n  = stop_q;
    data_n  = rx_data;
    vld_n   = 1'b0;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall_c) begin
          state_n = ST_START;
          idx_n   = '0;
          par_n   = 1'b0;
          stop_n  = 1'b0;
        end
      end
      ST_START: begin
        if (sample_c && ff1) state_n = ST_IDLE;
        else if (bit_end_c) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        // LSB arrives first, so shift in from the top.
        if (sample_c) shreg_n = {ff1, shreg[DATA_BITS-1:1]};
        if (bit_end_c) begin
          if (cnt_idx == IDX_W'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = cnt_idx + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample_c) par_n = ff1 ^ (^shreg) ^ 1'(PARITY_ODD);
        if (bit_end_c) begin
          state_n = ST_STOP;
          idx_n   = '0;
        end
      end
      ST_STOP: begin
        // Finish at the last stop bit's midpoint so a back-to-back start edge is caught.
        if (sample_c) begin
          if (cnt_idx == IDX_W'(STOP_BITS - 1)) begin
            state_n = ST_IDLE;
            if (stop_low_c)  ferr_n = 1'b1;
            else if (par_q)  perr_n = 1'b1;
            else begin
              data_n = shreg;
              vld_n  = 1'b1;
            end
          end else begin
            stop_n = stop_low_c;
          end
        end
        if (bit_end_c) idx_n = cnt_idx + IDX_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt_idx    <= '0;
      shreg      <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      rx_data    <= '0;
      rx_vld     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt_idx    <= idx_n;
      shreg      <= shreg_n;
      par_q      <= par_n;
      stop_q     <= stop_n;
      rx_data    <= data_n;
      rx_vld     <= vld_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the fixed 8N1, 9600-baud LED receiver.
- Generalised in clock/baud ratio, data width, parity and stop-bit count.
- Adds false-start rejection, stop/parity error detection, and a one-cycle valid strobe with held data word.
- Sits between the board rx pin and any consumer: LED bank, command decoder, FIFO.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. Derived BIT_CNT = CLK_FREQ/BAUD (5208 at defaults), integer-truncated. Must be ≥ 4.
- DATA_BITS, 8: payload bits per frame, legal 5..9.
- PARITY_EN, 0: 1 = a parity bit follows the data.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1: stop bits checked, legal 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_uart  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last error-free payload, LSB received first.
- rx_vld  output  1  one-cycle strobe: rx_data updated.
- parity_err  output  1  one-cycle strobe: parity mismatch, frame dropped.
- frame_err  output  1  one-cycle strobe: a stop bit sampled low, frame dropped.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset values: rx_data = all zeros; rx_vld, parity_err, frame_err, busy = 0; state IDLE; counters 0; synchroniser flops = 1.
- Input path: rx_uart -> ff0 -> ff1 (synchronised) -> ff2. Falling edge is ff1 == 0 && ff2 == 1. All sampling uses ff1.
- Bit timer: cnt_bit runs 0..BIT_CNT-1 while busy and clears at wrap. The sample point is cnt_bit == BIT_CNT/2-1. cnt_idx counts bits within the current state.
- IDLE -> START on a falling edge; cnt_bit starts at 0 on the following cycle.
- START: at the sample point, ff1 == 1 is a false start: return to IDLE with no strobes. Otherwise, at the end of the bit, go to DATA.
- DATA: shift ff1 into bit cnt_idx at each sample point, LSB first. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: expected bit = XOR of data, inverted when PARITY_ODD. Latch the mismatch at the sample point, then go to STOP at the end of the bit.
- STOP: sample each stop bit. For STOP_BITS = 2, the first stop bit waits a full bit period before the second is sampled. Latch any low sample. The frame completes at the sample point of the last stop bit, not its end, so a start edge following immediately can be caught.
- Frame completion, evaluated in priority order:
  - Any stop bit low: frame_err = 1 for one cycle.
  - Else parity mismatch: parity_err = 1 for one cycle.
  - Else rx_data <= assembled word and rx_vld = 1 for one cycle.
- All strobes assert on the cycle after the completing sample point. The state returns to IDLE on that same cycle.
- rx_data is held unchanged on error frames and on false starts.
- A falling edge is ignored outside IDLE. The edge detector is re-armed from IDLE only, so a line still low after a frame error does not retrigger until it has gone high.
- Reset mid-frame: asynchronous return to reset values. The partial frame is discarded and no strobe is issued.
- Latency: rx_vld follows the synchroniser edge by 1 + BIT_CNT*(1 + DATA_BITS + PARITY_EN + STOP_BITS - 1) + BIT_CNT/2 cycles, ±1.

Decomposition:
- Package uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP.
  - Function calc_bit_cnt(clk_freq, baud).
  - Legal-range constants for DATA_BITS and STOP_BITS.
- Sub-module uart_bit_timer holds the bit timer (cnt_bit wrap and sample-point pulse). It is enabled by busy and cleared on IDLE entry, and is reused by the future uart_tx_param.

Test Plan:
All scenarios use CLK_FREQ = 1_000_000 and BAUD = 100_000 (BIT_CNT = 10) unless noted.
1. 8N1 frame 0x5A -> exactly one rx_vld pulse; rx_data = 0x5A; no error strobes; busy is low afterwards.
2. Back-to-back frames 0x00 then 0xFF, next start bit placed immediately after the stop bit -> two rx_vld pulses; rx_data = 0x00 then 0xFF.
3. Line glitched low for 3 cycles in IDLE -> no strobes; busy high for about 5 cycles then low; rx_data unchanged.
4. Frame 0x3C with stop bit driven 0 -> frame_err pulse only; rx_data keeps its previous value (0xFF); the next good frame 0x11 is received after the line returns high.
5. PARITY_EN = 1, PARITY_ODD = 0: data 0x01 with parity bit 0 -> parity_err pulse; the same frame with parity bit 1 -> rx_vld and rx_data = 0x01.
6. rst_n pulsed low during data bit 4 of 0xA5 -> all outputs return to reset values immediately; a subsequent frame 0xC3 is received correctly. Run DATA_BITS = 7, STOP_BITS = 2 once as a regression with frame 0x55 -> rx_data = 0x55.
